// File: rtl/sprite_dirty_redraw_if.sv
// Compositor / back-RAM bus of the sprite dirty-rectangle writer.
//   pix_x, pix_y : scan coordinate presented to the compositor
//   pix_color    : colour returned by the compositor for pix_x/pix_y (same cycle)
//   wr_en        : back-RAM write strobe
//   wr_addr      : back-RAM word address
//   wr_data      : back-RAM write data
// The writer drives the master modport; compositor and RAM sit on the slave side.
interface sprite_dirty_redraw_if #(
  parameter int ADDR_W = 16
);
  logic [9:0]        pix_x;
  logic [9:0]        pix_y;
  logic [7:0]        pix_color;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (
    output pix_x, pix_y, wr_en, wr_addr, wr_data,
    input  pix_color
  );

  modport slave (
    input  pix_x, pix_y, wr_en, wr_addr, wr_data,
    output pix_color
  );
endinterface

// File: rtl/sprite_dirty_redraw.sv
// Dirty-rectangle writer for a ping-pong framebuffer.
// On every accepted frame_start the sprite state (x, y, attr) is latched. Each sprite
// whose state differs from what was last drawn into the current back buffer gets its
// old box and then its new box rescanned; the compositor colour for every scanned
// coordinate is written to the back RAM. Buffers swap on the frame_start that follows
// a completed redraw. One history table per buffer keeps both buffers coherent.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   frame_start       : one-cycle frame pulse
//   sprite_x/y/attr   : packed per-sprite state, sprite i at [10i+9:10i] / [ATTR_W*i +: ATTR_W]
//   bus               : compositor request/response and back-RAM write port
//   front_sel         : buffer being displayed (back buffer is ~front_sel)
//   swap              : one-cycle pulse when front_sel toggles
//   busy              : redraw in progress (LATCH, SCAN_OLD, SCAN_NEW, NEXT)
//   overrun           : sticky, frame_start seen while busy
module sprite_dirty_redraw #(
  parameter int NUM_SPRITES = 5,
  parameter int ATTR_W      = 7,
  parameter int SPR_SIZE    = 16,
  parameter int XMAX        = 240,
  parameter int YOFFSET     = 24,
  parameter int YROWS       = 264,
  parameter int ADDR_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_start,
  input  logic [NUM_SPRITES*10-1:0]     sprite_x,
  input  logic [NUM_SPRITES*10-1:0]     sprite_y,
  input  logic [NUM_SPRITES*ATTR_W-1:0] sprite_attr,
  sprite_dirty_redraw_if.master         bus,
  output logic                          front_sel,
  output logic                          swap,
  output logic                          busy,
  output logic                          overrun
);

  localparam int LOG_S = $clog2(SPR_SIZE);
  // One extra bit so the terminal compare never sees a wrapped counter.
  localparam int CNT_W = 2 * LOG_S + 1;
  localparam int LAST  = SPR_SIZE * SPR_SIZE - 1;
  localparam int H     = SPR_SIZE / 2 - 1;
  localparam int SW    = 20 + ATTR_W;
  localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LATCH    = 3'd1;
  localparam logic [2:0] S_SCAN_OLD = 3'd2;
  localparam logic [2:0] S_SCAN_NEW = 3'd3;
  localparam logic [2:0] S_NEXT     = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  // Coordinate of a box pixel, centred on loc, modulo 2^10.
  function automatic logic [9:0] scan_coord(input logic [9:0] loc, input logic [LOG_S-1:0] off);
    return loc - 10'(H) + 10'(off);
  endfunction

  // Wrapped negatives appear as large unsigned values and fail the upper bounds.
  function automatic logic in_frame(input logic [9:0] x, input logic [9:0] y);
    return (int'(x) < XMAX) && (int'(y) >= YOFFSET) && (int'(y) < YOFFSET + YROWS);
  endfunction

  // Framebuffer is stored column-major with x reversed.
  function automatic logic [ADDR_W-1:0] ram_addr(input logic [9:0] x, input logic [9:0] y);
    return ADDR_W'((XMAX - 1 - int'(x)) * YROWS + int'(y) - YOFFSET);
  endfunction

  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_SPRITES-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  logic [2:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_SPRITES-1:0] dirty_q, dirty_d;
  logic [SW-1:0]          cur_q  [NUM_SPRITES];
  logic [SW-1:0]          cur_d  [NUM_SPRITES];
  logic [SW-1:0]          prev_q [2][NUM_SPRITES];
  logic [SW-1:0]          prev_d [2][NUM_SPRITES];
  logic                   front_sel_q, front_sel_d;
  logic                   swap_q, swap_d;
  logic                   overrun_q, overrun_d;
  logic [9:0]             pix_x_q, pix_x_d;
  logic [9:0]             pix_y_q, pix_y_d;
  logic                   pix_vld_q, pix_vld_d;
  logic                   wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic [7:0]             wr_data_q, wr_data_d;

  logic                   back;
  logic                   busy_w;
  logic                   accept;
  logic [NUM_SPRITES-1:0] dirty_now;
  logic [NUM_SPRITES-1:0] rest_dirty;
  logic [9:0]             base_x, base_y;

  assign back   = ~front_sel_q;
  assign busy_w = (state_q == S_LATCH) || (state_q == S_SCAN_OLD) ||
                  (state_q == S_SCAN_NEW) || (state_q == S_NEXT);
  assign accept = frame_start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Compare against the history of the buffer about to be drawn into.
  always_comb begin
    for (int i = 0; i < NUM_SPRITES; i++) begin
      dirty_now[i] = (cur_q[i] != prev_q[back][i]);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    dirty_d     = dirty_q;
    cur_d       = cur_q;
    prev_d      = prev_q;
    front_sel_d = front_sel_q;
    swap_d      = 1'b0;
    overrun_d   = overrun_q;
    rest_dirty  = '0;

    if (frame_start && busy_w) overrun_d = 1'b1;

    if (accept) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        cur_d[i] = {sprite_x[10*i +: 10], sprite_y[10*i +: 10], sprite_attr[ATTR_W*i +: ATTR_W]};
      end
      state_d = S_LATCH;
      if (state_q == S_DONE) begin
        front_sel_d = ~front_sel_q;
        swap_d      = 1'b1;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: ;
      S_LATCH: begin
        dirty_d = dirty_now;
        cnt_d   = '0;
        if (|dirty_now) begin
          idx_d   = lowest_set(dirty_now);
          state_d = S_SCAN_OLD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SCAN_OLD: begin
        if (cnt_q == CNT_W'(LAST)) begin
          cnt_d   = '0;
          state_d = S_SCAN_NEW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SCAN_NEW: begin
        if (cnt_q == CNT_W'(LAST)) begin
          cnt_d   = '0;
          state_d = S_NEXT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_NEXT: begin
        prev_d[back][idx_q] = cur_q[idx_q];
        rest_dirty          = dirty_q & ~(NUM_SPRITES'(1) << idx_q);
        dirty_d             = rest_dirty;
        if (|rest_dirty) begin
          idx_d   = lowest_set(rest_dirty);
          state_d = S_SCAN_OLD;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Scan address is built from next-state values so the registered pix_x/pix_y
  // line up with the cycle the FSM spends on that count.
  always_comb begin
    pix_vld_d = (state_d == S_SCAN_OLD) || (state_d == S_SCAN_NEW);
    pix_x_d   = pix_x_q;
    pix_y_d   = pix_y_q;
    if (state_d == S_SCAN_OLD) begin
      base_x = prev_q[back][idx_d][SW-1 -: 10];
      base_y = prev_q[back][idx_d][SW-11 -: 10];
    end else begin
      base_x = cur_q[idx_d][SW-1 -: 10];
      base_y = cur_q[idx_d][SW-11 -: 10];
    end
    if (pix_vld_d) begin
      pix_x_d = scan_coord(base_x, cnt_d[LOG_S-1:0]);
      pix_y_d = scan_coord(base_y, cnt_d[2*LOG_S-1:LOG_S]);
    end
  end

  // Write stage: one cycle behind the scan coordinate.
  always_comb begin
    wr_en_d   = pix_vld_q && in_frame(pix_x_q, pix_y_q);
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (pix_vld_q) begin
      wr_addr_d = ram_addr(pix_x_q, pix_y_q);
      wr_data_d = bus.pix_color;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      dirty_q     <= '0;
      front_sel_q <= 1'b0;
      swap_q      <= 1'b0;
      overrun_q   <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_vld_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        cur_q[i]     <= '0;
        prev_q[0][i] <= {10'h3FF, 10'h3FF, {ATTR_W{1'b0}}};
        prev_q[1][i] <= {10'h3FF, 10'h3FF, {ATTR_W{1'b0}}};
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      dirty_q     <= dirty_d;
      front_sel_q <= front_sel_d;
      swap_q      <= swap_d;
      overrun_q   <= overrun_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_vld_q   <= pix_vld_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cur_q       <= cur_d;
      prev_q      <= prev_d;
    end
  end

  assign bus.pix_x   = pix_x_q;
  assign bus.pix_y   = pix_y_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign front_sel   = front_sel_q;
  assign swap        = swap_q;
  assign busy        = busy_w;
  assign overrun     = overrun_q;

endmodule
